// File: rtl/clkdiv_gen.sv
// Programmable mclk divider with start phase, glitch-free reload and clean stop.
// Optional rise counter port enabled by defining CLKDIV_RISECNT_EN.
module clkdiv_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div_val,
    input  logic [DIV_W-1:0] phase_val,
    output logic             bclk,
    output logic             bclk_rise,
    output logic             running
`ifdef CLKDIV_RISECNT_EN
    ,
    output logic [CNT_W-1:0] rise_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        PHASE,
        RUN
    } state_t;

    localparam logic [DIV_W:0]   ONE_C = {{DIV_W{1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] ONE_D = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [DIV_W:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0] half_s_q, half_s_d;
    logic [DIV_W-1:0] phase_s_q, phase_s_d;
    logic [DIV_W-1:0] half_a_q, half_a_d;
    logic             bclk_q, bclk_d;
    logic             rise_q, rise_d;
    logic             run_q, run_d;
    logic             stop_q, stop_d;

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] half_nxt;
    logic [DIV_W-1:0] phase_nxt;

    assign div_eff   = (div_val == '0) ? ONE_D : div_val;
    // A load on the very edge of a rise still wins over the older shadow.
    assign half_nxt  = load ? div_eff : half_s_q;
    assign phase_nxt = load ? phase_val : phase_s_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_s_d  = half_s_q;
        phase_s_d = phase_s_q;
        half_a_d  = half_a_q;
        bclk_d    = bclk_q;
        stop_d    = stop_q;
        rise_d    = 1'b0;
        if (load) begin
            half_s_d  = div_eff;
            phase_s_d = phase_val;
        end
        unique case (state_q)
            IDLE: begin
                bclk_d = 1'b0;
                stop_d = 1'b0;
                if (load) half_a_d = div_eff;
                if (en) begin
                    state_d = PHASE;
                    cnt_d   = {1'b0, phase_nxt} + ONE_C;
                end
            end
            PHASE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE_C;
                end else if (!en) begin
                    state_d = IDLE;
                end else begin
                    state_d  = RUN;
                    bclk_d   = 1'b1;
                    rise_d   = 1'b1;
                    half_a_d = half_nxt;
                    cnt_d    = {1'b0, half_nxt} - ONE_C;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE_C;
                end else if (bclk_q) begin
                    // Stop is decided here but the low half still runs out.
                    bclk_d = 1'b0;
                    cnt_d  = {1'b0, half_a_q} - ONE_C;
                    if (!en) stop_d = 1'b1;
                end else if (stop_q) begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                end else begin
                    bclk_d   = 1'b1;
                    rise_d   = 1'b1;
                    half_a_d = half_nxt;
                    cnt_d    = {1'b0, half_nxt} - ONE_C;
                end
            end
            default: begin
                state_d = IDLE;
                bclk_d  = 1'b0;
            end
        endcase
        run_d = (state_d != IDLE);
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            half_s_q  <= ONE_D;
            phase_s_q <= '0;
            half_a_q  <= ONE_D;
            bclk_q    <= 1'b0;
            rise_q    <= 1'b0;
            run_q     <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_s_q  <= half_s_d;
            phase_s_q <= phase_s_d;
            half_a_q  <= half_a_d;
            bclk_q    <= bclk_d;
            rise_q    <= rise_d;
            run_q     <= run_d;
            stop_q    <= stop_d;
        end
    end

    assign bclk      = bclk_q;
    assign bclk_rise = rise_q;
    assign running   = run_q;

`ifdef CLKDIV_RISECNT_EN
    localparam logic [CNT_W-1:0] ONE_R = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] rcnt_q, rcnt_d;

    always_comb begin
        rcnt_d = rcnt_q;
        if (state_q == IDLE && load) rcnt_d = '0;
        if (rise_d) rcnt_d = rcnt_q + ONE_R;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) rcnt_q <= '0;
        else        rcnt_q <= rcnt_d;
    end

    assign rise_cnt = rcnt_q;
`endif

endmodule

// File: tb/tb_clkdiv_gen.sv
// Scoreboard bench for clkdiv_gen: expected bclk edges (kind, mclk cycle)
// are queued by stimulus and popped by an edge monitor.
module tb_clkdiv_gen;

    typedef struct {
        bit rise;
        int cyc;
    } edge_t;

    logic       mclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] div_val = '0;
    logic [7:0] phase_val = '0;
    logic       bclk;
    logic       bclk_rise;
    logic       running;
`ifdef CLKDIV_RISECNT_EN
    logic [15:0] rise_cnt;
`endif

    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;
    logic  prev_b = 1'b0;
    edge_t exp_q[$];

    clkdiv_gen #(.DIV_W(8), .CNT_W(16)) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .div_val   (div_val),
        .phase_val (phase_val),
        .bclk      (bclk),
        .bclk_rise (bclk_rise),
        .running   (running)
`ifdef CLKDIV_RISECNT_EN
        ,
        .rise_cnt  (rise_cnt)
`endif
    );

    always #10 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input bit r, input int c);
        edge_t e;
        e.rise = r;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge mclk);
    endtask

    // Issues load+en on the next edge e0; returns the expected first rise cycle.
    task automatic start(input int d, input int p, output int r0);
        int e0;
        div_val   = 8'(d);
        phase_val = 8'(p);
        load      = 1'b1;
        en        = 1'b1;
        e0        = cyc + 1;
        r0        = e0 + 2 + p;
        @(negedge mclk);
        load = 1'b0;
    endtask

    always @(negedge mclk) begin
        edge_t e;
        if (mon_en) begin
            if (bclk !== prev_b) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL edge_unexpected: bclk=%0d at cyc %0d, required no edge",
                             bclk, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("edge_kind", int'(bclk), int'(e.rise));
                    chk("edge_cyc", cyc, e.cyc);
                    if (bclk) chk("rise_strobe", int'(bclk_rise), 1);
                end
            end else if (bclk_rise) begin
                chk("rise_without_edge", int'(bclk_rise), 0);
            end
        end
        prev_b = bclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        repeat (3) @(negedge mclk);
        chk("reset_bclk", int'(bclk), 0);
        chk("reset_rise", int'(bclk_rise), 0);
        chk("reset_running", int'(running), 0);
`ifdef CLKDIV_RISECNT_EN
        chk("reset_rise_cnt", int'(rise_cnt), 0);
`endif
        rst_n  = 1'b1;
        @(negedge mclk);
        mon_en = 1'b1;

        // Reset in the middle of a high half.
        start(5, 0, r0);
        push(1'b1, r0);
        wait_cyc(r0 + 2);
        chk("t1_bclk_high", int'(bclk), 1);
        mon_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("t1_async_bclk", int'(bclk), 0);
        chk("t1_async_running", int'(running), 0);
        exp_q.delete();
        en = 1'b0;
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
        @(negedge mclk);
        mon_en = 1'b1;

        // div=5 restart, then reload div=2 mid high half, then stop.
        start(5, 0, r0);
        chk("t2_running", int'(running), 1);
        for (int k = 0; k < 4; k++) begin
            push(1'b1, r0 + 10 * k);
            push(1'b0, r0 + 10 * k + 5);
        end
        push(1'b1, r0 + 40);
        push(1'b0, r0 + 45);
        push(1'b1, r0 + 50);
        push(1'b0, r0 + 52);
        push(1'b1, r0 + 54);
        push(1'b0, r0 + 56);
        push(1'b1, r0 + 58);
        push(1'b0, r0 + 60);
        wait_cyc(r0 + 42);
        div_val = 8'd2;
        load    = 1'b1;
        @(negedge mclk);
        load = 1'b0;
        wait_cyc(r0 + 58);
        en = 1'b0;
        wait_cyc(r0 + 61);
        chk("t3_running_low_half", int'(running), 1);
        wait_cyc(r0 + 62);
        chk("t3_stopped", int'(running), 0);
        chk("t3_bclk_low", int'(bclk), 0);

        // Phase 3, div 1.
        start(1, 3, r0);
        for (int k = 0; k < 4; k++) begin
            push(1'b1, r0 + 2 * k);
            push(1'b0, r0 + 2 * k + 1);
        end
        wait_cyc(r0 - 1);
        chk("t4_phase_running", int'(running), 1);
        wait_cyc(r0 + 6);
        en = 1'b0;
        wait_cyc(r0 + 8);
        chk("t4_stopped", int'(running), 0);

        // div 4, en dropped during high half.
        start(4, 0, r0);
        push(1'b1, r0);
        push(1'b0, r0 + 4);
        push(1'b1, r0 + 8);
        push(1'b0, r0 + 12);
        wait_cyc(r0 + 9);
        en = 1'b0;
        wait_cyc(r0 + 15);
        chk("t5_running_low_half", int'(running), 1);
        wait_cyc(r0 + 16);
        chk("t5_stopped", int'(running), 0);
        chk("t5_bclk_low", int'(bclk), 0);

        // div 0 behaves as div 1; ten rises.
        start(0, 0, r0);
        for (int k = 0; k < 10; k++) begin
            push(1'b1, r0 + 2 * k);
            push(1'b0, r0 + 2 * k + 1);
        end
        wait_cyc(r0 + 18);
        en = 1'b0;
`ifdef CLKDIV_RISECNT_EN
        chk("t6_rise_cnt", int'(rise_cnt), 10);
`endif
        wait_cyc(r0 + 20);
        chk("t6_stopped", int'(running), 0);
`ifdef CLKDIV_RISECNT_EN
        repeat (4) @(negedge mclk);
        chk("t6_rise_cnt_hold", int'(rise_cnt), 10);
`endif

        repeat (6) @(negedge mclk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
